s3g_rx_tx: RTL and testbench
============================

S3G_RX_TX -- requirements
Module: s3g_rx_tx

Interface
REQ-001 Parameters: none; all constants are fixed and come from the shared package.
REQ-002 clk  in  1  single system clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 rx_data  in  8  received UART byte, valid when rx_done=1.
REQ-005 rx_done  in  1  one-cycle strobe, one byte received.
REQ-006 rx_ready  out  1  one-cycle pulse, valid packet with good CRC received.
REQ-007 rx_crc_error  out  1  one-cycle pulse, packet received with bad CRC.
REQ-008 rx_len_error  out  1  one-cycle pulse, length byte >8 rejected.
REQ-009 rx_len  out  8  payload length of last packet.
REQ-010 rx_buf0..rx_buf7  out  8 each  received payload bytes 0..7.
REQ-011 packet_wr  in  1  one-cycle strobe, start transmitting a packet.
REQ-012 payload_len  in  8  payload byte count, sampled on packet_wr.
REQ-013 buf0..buf7  in  8 each  transmit payload, sampled on packet_wr.
REQ-014 tx_data  out  8  byte for UART transmitter, stable while tx_wr=1 and until tx_done.
REQ-015 tx_wr  out  1  one-cycle pulse, load tx_data into UART.
REQ-016 tx_done  in  1  one-cycle strobe, UART finished the current byte.
REQ-017 tx_busy  out  1  high from accepted packet_wr until tx_done of the CRC byte.

Function
REQ-018 Frame format is 0xD5, length L (0..8), L payload bytes, then CRC-8.
REQ-019 CRC is Dallas/Maxim CRC-8, reflected poly 0x8C, init 0x00, LSB first, over payload bytes only.
REQ-020 RX FSM has states IDLE, LEN, PAYLOAD and CRC, and advances only on rx_done.
REQ-021 IDLE: 0xD5 -> LEN; any other byte is discarded.
REQ-022 LEN: L>8 -> IDLE with rx_len_error pulse; L=0 -> CRC; otherwise -> PAYLOAD, and the CRC accumulator clears.
REQ-023 PAYLOAD: store byte i in rx_buf[i] and update the CRC; after byte L-1 -> CRC. A 0xD5 inside the payload is ordinary data.
REQ-024 CRC: if the byte equals the accumulator, rx_ready pulses; otherwise rx_crc_error pulses. Both go -> IDLE.
REQ-025 rx_ready and rx_crc_error are registered and assert the cycle after the rx_done carrying the CRC byte.
REQ-026 rx_len and rx_buf* hold their values until overwritten by the next frame; rx_buf bytes beyond L are unchanged.
REQ-027 TX FSM has states IDLE, START, LEN, PAYLOAD and CRC.
REQ-028 packet_wr in IDLE with payload_len<=8 latches payload_len and buf0..7, and asserts tx_busy.
REQ-029 packet_wr with payload_len>8 is ignored, and so is packet_wr while tx_busy=1.
REQ-030 Each byte is presented with tx_data plus a one-cycle tx_wr pulse. The first tx_wr occurs the cycle after packet_wr; each later tx_wr occurs the cycle after the tx_done for the previous byte.
REQ-031 Byte order is 0xD5, L, payload[0..L-1], CRC, giving L+3 tx_wr pulses.
REQ-032 tx_busy drops the cycle after the final tx_done.
REQ-033 tx_done is ignored when no byte is outstanding.
REQ-034 RX and TX are fully independent; simultaneous rx_done and tx_done are both serviced in the same cycle.

Reset
REQ-035 On rst low, both FSMs go to IDLE, and all outputs, counters and CRC accumulators go to 0, asynchronously.
REQ-036 Reset mid-frame aborts the frame without any pulse; a partially sent TX frame is not resumed.

Structure
REQ-037 Package s3g_pkg holds START_BYTE=8'hD5, MAX_PAYLOAD=8, CRC_POLY=8'h8C and the RX/TX state enums.
REQ-038 Sub-module crc8_maxim is a combinational next_crc=f(crc, byte) update, instantiated once in RX and once in TX.

Verification
REQ-039 RX bytes 0x0D, D5, 03, 01, 02, 03, D8 -> 0x0D is ignored; one rx_ready pulse; rx_len=3; rx_buf0..2=01,02,03.
REQ-040 Same frame with CRC byte 0xCC -> one rx_crc_error pulse, no rx_ready.
REQ-041 RX bytes D5, 09 -> rx_len_error pulse; a following D5, 00, 00 -> rx_ready with rx_len=0.
REQ-042 packet_wr with payload_len=3, buf=01,02,03, and tx_done after every byte -> tx_data sequence D5, 03, 01, 02, 03, D8; exactly 6 tx_wr pulses; tx_busy low after the 6th tx_done.
REQ-043 Second packet_wr while busy, and tx_done pulses with none pending -> no extra tx_wr; sequence unchanged.
REQ-044 rst low in the middle of RX PAYLOAD and TX PAYLOAD -> all outputs 0, both FSMs IDLE; a fresh valid frame afterwards completes normally.

Source files
------------

// File: rtl/s3g_rx_tx_pkg.sv
// Shared constants and FSM state encodings for the S3G framed byte link.
// Frame: START_BYTE, length, payload, Dallas/Maxim CRC-8 over the payload.
package s3g_pkg;
    localparam logic [7:0] START_BYTE  = 8'hD5;
    localparam logic [7:0] MAX_PAYLOAD = 8'd8;
    localparam logic [7:0] CRC_POLY    = 8'h8C;

    typedef enum logic [1:0] {RX_IDLE, RX_LEN, RX_PAYLOAD, RX_CRC} rx_state_e;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_LEN, TX_PAYLOAD, TX_CRC} tx_state_e;
endpackage

// File: rtl/s3g_rx_tx_if.sv
// Byte-level RX/TX handshake bundle between the framer and its UART/host side.
interface s3g_rx_tx_if;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_ready, rx_crc_error, rx_len_error;
    logic [7:0] rx_len;
    logic [7:0] rx_buf0, rx_buf1, rx_buf2, rx_buf3, rx_buf4, rx_buf5, rx_buf6, rx_buf7;
    logic       packet_wr;
    logic [7:0] payload_len;
    logic [7:0] buf0, buf1, buf2, buf3, buf4, buf5, buf6, buf7;
    logic [7:0] tx_data;
    logic       tx_wr, tx_done, tx_busy;

    modport slave (
        input  rx_data, rx_done, packet_wr, payload_len, tx_done,
               buf0, buf1, buf2, buf3, buf4, buf5, buf6, buf7,
        output rx_ready, rx_crc_error, rx_len_error, rx_len, tx_data, tx_wr, tx_busy,
               rx_buf0, rx_buf1, rx_buf2, rx_buf3, rx_buf4, rx_buf5, rx_buf6, rx_buf7
    );
    modport master (
        output rx_data, rx_done, packet_wr, payload_len, tx_done,
               buf0, buf1, buf2, buf3, buf4, buf5, buf6, buf7,
        input  rx_ready, rx_crc_error, rx_len_error, rx_len, tx_data, tx_wr, tx_busy,
               rx_buf0, rx_buf1, rx_buf2, rx_buf3, rx_buf4, rx_buf5, rx_buf6, rx_buf7
    );
endinterface

// File: rtl/s3g_rx_tx_crc8_maxim.sv
// One-byte Dallas/Maxim CRC-8 step (reflected poly, data consumed LSB first).
module crc8_maxim
    import s3g_pkg::*;
(
    input  logic [7:0] crc,
    input  logic [7:0] data,
    output logic [7:0] next_crc
);
    logic [7:0] c;

    always_comb begin
        c = crc;
        for (int i = 0; i < 8; i++)
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        next_crc = c;
    end
endmodule

// File: rtl/s3g_rx_tx.sv
// Framed packet receiver and transmitter on top of a byte UART; RX and TX
// paths are independent and each keeps its own CRC accumulator.
module s3g_rx_tx
    import s3g_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    s3g_rx_tx_if.slave  bus
);
    // ---------------- receive path ----------------
    rx_state_e        rx_state;
    logic [3:0]       rx_idx;
    logic [7:0]       rx_crc, rx_crc_nxt, rx_len_q;
    logic [7:0][7:0]  rx_buf;
    logic             rx_ready_q, rx_crc_err_q, rx_len_err_q;

    crc8_maxim u_rx_crc (.crc(rx_crc), .data(bus.rx_data), .next_crc(rx_crc_nxt));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state     <= RX_IDLE;
            rx_idx       <= '0;
            rx_crc       <= '0;
            rx_len_q     <= '0;
            rx_buf       <= '0;
            rx_ready_q   <= 1'b0;
            rx_crc_err_q <= 1'b0;
            rx_len_err_q <= 1'b0;
        end else begin
            rx_ready_q   <= 1'b0;
            rx_crc_err_q <= 1'b0;
            rx_len_err_q <= 1'b0;
            if (bus.rx_done) begin
                case (rx_state)
                    RX_IDLE:
                        if (bus.rx_data == START_BYTE) rx_state <= RX_LEN;
                    RX_LEN:
                        if (bus.rx_data > MAX_PAYLOAD) begin
                            rx_len_err_q <= 1'b1;
                            rx_state     <= RX_IDLE;
                        end else begin
                            rx_len_q <= bus.rx_data;
                            rx_crc   <= '0;
                            rx_idx   <= '0;
                            rx_state <= (bus.rx_data == 8'd0) ? RX_CRC : RX_PAYLOAD;
                        end
                    RX_PAYLOAD: begin
                        rx_buf[rx_idx[2:0]] <= bus.rx_data;
                        rx_crc              <= rx_crc_nxt;
                        rx_idx              <= rx_idx + 4'd1;
                        if (rx_idx == rx_len_q[3:0] - 4'd1) rx_state <= RX_CRC;
                    end
                    RX_CRC: begin
                        if (bus.rx_data == rx_crc) rx_ready_q   <= 1'b1;
                        else                       rx_crc_err_q <= 1'b1;
                        rx_state <= RX_IDLE;
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end

    assign bus.rx_ready     = rx_ready_q;
    assign bus.rx_crc_error = rx_crc_err_q;
    assign bus.rx_len_error = rx_len_err_q;
    assign bus.rx_len       = rx_len_q;
    assign bus.rx_buf0 = rx_buf[0];
    assign bus.rx_buf1 = rx_buf[1];
    assign bus.rx_buf2 = rx_buf[2];
    assign bus.rx_buf3 = rx_buf[3];
    assign bus.rx_buf4 = rx_buf[4];
    assign bus.rx_buf5 = rx_buf[5];
    assign bus.rx_buf6 = rx_buf[6];
    assign bus.rx_buf7 = rx_buf[7];

    // ---------------- transmit path ----------------
    tx_state_e        tx_state;
    logic [3:0]       tx_idx, tx_len;
    logic [7:0][7:0]  tx_buf;
    logic [7:0]       tx_crc, tx_crc_nxt, tx_data_q;
    logic             tx_wr_q, tx_busy_q;

    // CRC is folded in as each payload byte is handed to the UART, so the
    // accumulator is final by the time the CRC byte is loaded.
    crc8_maxim u_tx_crc (.crc(tx_crc), .data(tx_buf[tx_idx[2:0]]), .next_crc(tx_crc_nxt));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state  <= TX_IDLE;
            tx_idx    <= '0;
            tx_len    <= '0;
            tx_buf    <= '0;
            tx_crc    <= '0;
            tx_data_q <= '0;
            tx_wr_q   <= 1'b0;
            tx_busy_q <= 1'b0;
        end else begin
            tx_wr_q <= 1'b0;
            case (tx_state)
                TX_IDLE:
                    if (bus.packet_wr && bus.payload_len <= MAX_PAYLOAD) begin
                        tx_len    <= bus.payload_len[3:0];
                        tx_buf    <= {bus.buf7, bus.buf6, bus.buf5, bus.buf4,
                                      bus.buf3, bus.buf2, bus.buf1, bus.buf0};
                        tx_crc    <= '0;
                        tx_idx    <= '0;
                        tx_data_q <= START_BYTE;
                        tx_wr_q   <= 1'b1;
                        tx_busy_q <= 1'b1;
                        tx_state  <= TX_START;
                    end
                TX_START:
                    if (bus.tx_done) begin
                        tx_data_q <= {4'd0, tx_len};
                        tx_wr_q   <= 1'b1;
                        tx_state  <= TX_LEN;
                    end
                // tx_idx is still 0 in LEN, so both states share the load step
                TX_LEN, TX_PAYLOAD:
                    if (bus.tx_done) begin
                        tx_wr_q <= 1'b1;
                        if (tx_idx == tx_len) begin
                            tx_data_q <= tx_crc;
                            tx_state  <= TX_CRC;
                        end else begin
                            tx_data_q <= tx_buf[tx_idx[2:0]];
                            tx_crc    <= tx_crc_nxt;
                            tx_idx    <= tx_idx + 4'd1;
                            tx_state  <= TX_PAYLOAD;
                        end
                    end
                TX_CRC:
                    if (bus.tx_done) begin
                        tx_busy_q <= 1'b0;
                        tx_state  <= TX_IDLE;
                    end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    assign bus.tx_data = tx_data_q;
    assign bus.tx_wr   = tx_wr_q;
    assign bus.tx_busy = tx_busy_q;
endmodule

// File: tb/tb_s3g_rx_tx.sv
// Randomized plus directed bench for s3g_rx_tx against a frame-level model.
module tb_s3g_rx_tx;
    logic clk, rst;
    s3g_rx_tx_if bus ();

    s3g_rx_tx u_dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0, bad = 0;

    // monitor: counts output pulses and logs every byte handed to the UART
    int n_ready = 0, n_crc_err = 0, n_len_err = 0;
    logic [7:0] txq[$];
    always @(negedge clk) begin
        if (bus.rx_ready)     n_ready++;
        if (bus.rx_crc_error) n_crc_err++;
        if (bus.rx_len_error) n_len_err++;
        if (bus.tx_wr)        txq.push_back(bus.tx_data);
    end

    // model state
    int exp_ready = 0, exp_crc_err = 0, exp_len_err = 0;
    logic [7:0] exp_rx_len = 8'd0;
    logic [7:0] exp_buf[8];
    logic [7:0] exp_tx[$];
    logic [7:0] rxq[$];
    logic [7:0] tx_pl[8], rx_pl[8];
    int tx_base = 0;

    // CRC as a bit-serial division over the concatenated payload bit stream
    function automatic logic [7:0] ref_crc(input logic [7:0] p[8], input int n);
        logic [7:0] r;
        logic fb;
        r = 8'd0;
        for (int k = 0; k < n * 8; k++) begin
            fb = r[0] ^ p[k / 8][k % 8];
            r  = {1'b0, r[7:1]} ^ (fb ? 8'h8C : 8'h00);
        end
        return r;
    endfunction

    function automatic logic [7:0] obs_buf(input int i);
        case (i)
            0: return bus.rx_buf0;  1: return bus.rx_buf1;
            2: return bus.rx_buf2;  3: return bus.rx_buf3;
            4: return bus.rx_buf4;  5: return bus.rx_buf5;
            6: return bus.rx_buf6;  default: return bus.rx_buf7;
        endcase
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        chk({tag, ".ready_cnt"},   n_ready,   exp_ready);
        chk({tag, ".crc_err_cnt"}, n_crc_err, exp_crc_err);
        chk({tag, ".len_err_cnt"}, n_len_err, exp_len_err);
        chk({tag, ".rx_len"}, 32'(bus.rx_len), 32'(exp_rx_len));
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s.rx_buf%0d", tag, i), 32'(obs_buf(i)), 32'(exp_buf[i]));
        n = txq.size() - tx_base;
        chk({tag, ".tx_count"}, n, exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < n; i++)
            chk($sformatf("%s.tx_byte%0d", tag, i), 32'(txq[tx_base + i]), 32'(exp_tx[i]));
        chk({tag, ".tx_busy"}, 32'(bus.tx_busy), 0);
        chk({tag, ".tx_wr"},   32'(bus.tx_wr), 0);
        tx_base = txq.size();
        exp_tx.delete();
    endtask

    task automatic add_junk(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            do b = 8'($urandom); while (b == 8'hD5);
            rxq.push_back(b);
        end
    endtask

    // kind 0: good CRC, 1: corrupted CRC, 2: oversize length
    task automatic add_rx_rand(input int kind);
        int L;
        rxq.push_back(8'hD5);
        if (kind == 2) begin
            rxq.push_back(8'($urandom_range(9, 255)));
            exp_len_err++;
            return;
        end
        L = $urandom_range(0, 8);
        for (int i = 0; i < 8; i++) rx_pl[i] = 8'($urandom);
        rxq.push_back(8'(L));
        for (int i = 0; i < L; i++) begin
            rxq.push_back(rx_pl[i]);
            exp_buf[i] = rx_pl[i];
        end
        exp_rx_len = 8'(L);
        if (kind == 0) begin
            rxq.push_back(ref_crc(rx_pl, L));
            exp_ready++;
        end else begin
            rxq.push_back(ref_crc(rx_pl, L) ^ 8'($urandom_range(1, 255)));
            exp_crc_err++;
        end
    endtask

    // drives queued RX bytes and (optionally) one TX packet with a UART
    // responder; abort_at >= 0 pulls reset at that loop cycle
    task automatic run_bus(input bit issue, input int L, input int rx_pct,
                           input int dmax, input int abort_at);
        int cyc = 0, dly = 0;
        bit pend = 0;
        if (issue) begin
            bus.packet_wr = 1'b1;  bus.payload_len = 8'(L);
            bus.buf0 = tx_pl[0];  bus.buf1 = tx_pl[1];  bus.buf2 = tx_pl[2];  bus.buf3 = tx_pl[3];
            bus.buf4 = tx_pl[4];  bus.buf5 = tx_pl[5];  bus.buf6 = tx_pl[6];  bus.buf7 = tx_pl[7];
            if (L <= 8) begin
                exp_tx.push_back(8'hD5);
                exp_tx.push_back(8'(L));
                for (int i = 0; i < L; i++) exp_tx.push_back(tx_pl[i]);
                exp_tx.push_back(ref_crc(tx_pl, L));
            end
            @(posedge clk); #1;
            bus.packet_wr = 1'b0;
        end
        while ((rxq.size() > 0 || bus.tx_busy || pend) && cyc <= 3000) begin
            bus.rx_done = 1'b0;  bus.tx_done = 1'b0;  bus.packet_wr = 1'b0;
            if (cyc == abort_at) begin
                rst = 1'b0;
                #1;
                rxq.delete();
                exp_tx.delete();
                exp_rx_len = 8'd0;
                for (int i = 0; i < 8; i++) exp_buf[i] = 8'd0;
                tx_base = txq.size();
                chk("abort.tx_data", 32'(bus.tx_data), 0);
                check_all("abort");
                @(posedge clk); #1;
                rst = 1'b1;
                return;
            end
            if (bus.tx_wr) begin
                pend = 1;
                dly  = $urandom_range(0, dmax);
            end else if (pend) begin
                if (dly == 0) begin bus.tx_done = 1'b1; pend = 0; end
                else dly--;
            end else if (!bus.tx_busy && $urandom_range(0, 3) == 0) begin
                bus.tx_done = 1'b1;
            end
            if (bus.tx_busy && (cyc == 0 || $urandom_range(0, 5) == 0)) begin
                bus.packet_wr   = 1'b1;
                bus.payload_len = 8'($urandom_range(0, 8));
                bus.buf0        = 8'($urandom);
            end
            if (rxq.size() > 0 && $urandom_range(0, 99) < rx_pct) begin
                bus.rx_data = rxq.pop_front();
                bus.rx_done = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("no_hang", (cyc <= 3000) ? 1 : 0, 1);
        bus.rx_done = 1'b0;  bus.tx_done = 1'b0;  bus.packet_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        bus.rx_data = 8'd0;  bus.rx_done = 1'b0;  bus.packet_wr = 1'b0;
        bus.payload_len = 8'd0;  bus.tx_done = 1'b0;
        bus.buf0 = 8'd0;  bus.buf1 = 8'd0;  bus.buf2 = 8'd0;  bus.buf3 = 8'd0;
        bus.buf4 = 8'd0;  bus.buf5 = 8'd0;  bus.buf6 = 8'd0;  bus.buf7 = 8'd0;
        for (int i = 0; i < 8; i++) exp_buf[i] = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.tx_data", 32'(bus.tx_data), 0);
        chk("reset.rx_ready", 32'(bus.rx_ready), 0);
        check_all("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // junk byte, then a good 3-byte frame
        rxq = '{8'h0D, 8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hD8};
        exp_ready++;  exp_rx_len = 8'd3;
        exp_buf[0] = 8'h01;  exp_buf[1] = 8'h02;  exp_buf[2] = 8'h03;
        run_bus(0, 9, 50, 0, -1);
        check_all("rx_good");

        // same frame with a wrong CRC byte
        rxq = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hCC};
        exp_crc_err++;
        run_bus(0, 9, 50, 0, -1);
        check_all("rx_badcrc");

        // oversize length, then an empty frame
        rxq = '{8'hD5, 8'h09, 8'hD5, 8'h00, 8'h00};
        exp_len_err++;  exp_ready++;  exp_rx_len = 8'd0;
        run_bus(0, 9, 100, 0, -1);
        check_all("rx_len0");

        // 3-byte transmit, a re-issue while busy, and stray tx_done pulses
        for (int i = 0; i < 8; i++) tx_pl[i] = 8'd0;
        tx_pl[0] = 8'h01;  tx_pl[1] = 8'h02;  tx_pl[2] = 8'h03;
        run_bus(0, 9, 50, 0, -1);
        run_bus(1, 3, 50, 2, -1);
        chk("tx3.crc_byte", 32'(txq[txq.size() - 1]), 32'(8'hD8));
        check_all("tx3");

        // oversize packet_wr is ignored
        run_bus(1, 12, 50, 0, -1);
        check_all("tx_oversize");

        // reset mid-payload on both paths, then a fresh frame each way
        for (int i = 0; i < 8; i++) tx_pl[i] = 8'($urandom);
        rxq.push_back(8'hD5);  rxq.push_back(8'd8);
        for (int i = 0; i < 8; i++) rxq.push_back(8'($urandom));
        run_bus(1, 8, 100, 0, 5);
        add_rx_rand(0);
        run_bus(1, 5, 100, 0, -1);
        check_all("post_reset");

        // randomized concurrent traffic
        for (int it = 0; it < 30; it++) begin
            int k, L;
            add_junk($urandom_range(0, 2));
            k = $urandom_range(0, 3);
            add_rx_rand(k == 3 ? 0 : k);
            for (int i = 0; i < 8; i++) tx_pl[i] = 8'($urandom);
            L = ($urandom_range(0, 7) == 0) ? $urandom_range(9, 255) : $urandom_range(0, 8);
            run_bus(1, L, (it % 3 == 0) ? 100 : 40, (it % 2) * 3, -1);
            check_all($sformatf("rand%0d", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
